// File: rtl/lms_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lms_pkg                                                                    |
// | Shared constants for the LMS filter and its error monitor.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lms_pkg;

    localparam int c_W1 = 16;
    localparam int c_W2 = 16;
    localparam int c_WM = 32;

    localparam logic [1:0] c_ST_ACQUIRE   = 2'd0;
    localparam logic [1:0] c_ST_CONVERGED = 2'd1;
    localparam logic [1:0] c_ST_DIVERGED  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lms_sq_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lms_sq_acc                                                                 |
// | Square / accumulate pipeline producing mean-square error per window.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lms_sq_acc
    import lms_pkg::*;
#(
    parameter int W2    = c_W2,
    parameter int LOG_N = 4,
    parameter int WM    = c_WM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic signed [W2-1:0] e_in,
    input  logic                 e_valid,
    output logic [WM-1:0]        mse_out,
    output logic                 mse_valid
);

    localparam int             c_AW   = 2 * W2 + LOG_N;
    localparam logic [LOG_N-1:0] c_LAST = '1;
    localparam logic [LOG_N-1:0] c_ONE  = LOG_N'(1);

    logic signed [W2-1:0]   r_e;
    logic                   r_v1;
    logic [2*W2-1:0]        r_sq;
    logic                   r_v2;
    logic [c_AW-1:0]        r_acc;
    logic [LOG_N-1:0]       r_cnt;
    logic [WM-1:0]          r_mse;
    logic                   r_mse_valid;

    logic signed [2*W2-1:0] w_ext;
    logic signed [2*W2-1:0] w_prod;
    logic [c_AW-1:0]        w_sum;
    logic [c_AW-1:0]        w_shift;

    // Full-width signed square: (-2^(W2-1))^2 still fits as a positive value.
    assign w_ext   = {{W2{r_e[W2-1]}}, r_e};
    assign w_prod  = w_ext * w_ext;
    assign w_sum   = r_acc + {{LOG_N{1'b0}}, r_sq};
    assign w_shift = w_sum >> LOG_N;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e         <= '0;
            r_v1        <= 1'b0;
            r_sq        <= '0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mse       <= '0;
            r_mse_valid <= 1'b0;
        end else if (restart) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mse_valid <= 1'b0;
        end else begin
            r_v1        <= e_valid;
            r_v2        <= r_v1;
            r_mse_valid <= 1'b0;
            if (e_valid) begin
                r_e <= e_in;
            end
            if (r_v1) begin
                r_sq <= $unsigned(w_prod);
            end
            if (r_v2) begin
                if (r_cnt == c_LAST) begin
                    r_mse       <= WM'(w_shift);
                    r_mse_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

    assign mse_out   = r_mse;
    assign mse_valid = r_mse_valid;

endmodule
`default_nettype wire

// File: rtl/lms_err_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lms_err_monitor                                                            |
// | Windowed MSE of the LMS error with convergence / divergence tracking.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lms_err_monitor
    import lms_pkg::*;
#(
    parameter int W2    = c_W2,
    parameter int LOG_N = 4,
    parameter int HOLD  = 3,
    parameter int WM    = c_WM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W2-1:0] e_in,
    input  logic                 e_valid,
    input  logic                 restart,
    input  logic [WM-1:0]        thr_lo,
    input  logic [WM-1:0]        thr_hi,
    output logic [WM-1:0]        mse_out,
    output logic                 mse_valid,
    output logic                 converged,
    output logic                 alarm
);

    localparam int              c_HW       = $clog2(HOLD + 2);
    localparam logic [c_HW-1:0] c_HOLD     = c_HW'(HOLD);
    localparam logic [c_HW-1:0] c_HOLD_ONE = c_HW'(1);

    logic [WM-1:0]   w_mse;
    logic            w_mse_valid;
    logic [c_HW-1:0] w_hold_nxt;

    logic [1:0]      r_state;
    logic [c_HW-1:0] r_hold;
    logic            r_converged;
    logic            r_alarm;

    lms_sq_acc #(
        .W2    (W2),
        .LOG_N (LOG_N),
        .WM    (WM)
    ) u_sq_acc (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .e_in      (e_in),
        .e_valid   (e_valid),
        .mse_out   (w_mse),
        .mse_valid (w_mse_valid)
    );

    always_comb begin
        w_hold_nxt = r_hold;
        if (r_hold != c_HOLD) begin
            w_hold_nxt = r_hold + c_HOLD_ONE;
        end
    end

    // Evaluated only on a window result; DIVERGED is left only via reset/restart.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_state     <= c_ST_ACQUIRE;
            r_hold      <= '0;
            r_converged <= 1'b0;
            r_alarm     <= 1'b0;
        end else if (w_mse_valid) begin
            case (r_state)
                c_ST_ACQUIRE: begin
                    if (w_mse < thr_lo) begin
                        if (w_hold_nxt == c_HOLD) begin
                            r_state     <= c_ST_CONVERGED;
                            r_hold      <= '0;
                            r_converged <= 1'b1;
                        end else begin
                            r_hold <= w_hold_nxt;
                        end
                    end else begin
                        r_hold <= '0;
                    end
                end
                c_ST_CONVERGED: begin
                    if (w_mse > thr_hi) begin
                        r_state     <= c_ST_DIVERGED;
                        r_converged <= 1'b0;
                        r_alarm     <= 1'b1;
                    end
                end
                c_ST_DIVERGED: begin
                    r_state <= c_ST_DIVERGED;
                end
                default: begin
                    r_state     <= c_ST_ACQUIRE;
                    r_hold      <= '0;
                    r_converged <= 1'b0;
                    r_alarm     <= 1'b0;
                end
            endcase
        end
    end

    assign mse_out   = w_mse;
    assign mse_valid = w_mse_valid;
    assign converged = r_converged;
    assign alarm     = r_alarm;

endmodule
`default_nettype wire
